// File: rtl/serial_sub5_if.sv
// Operand/result handshake bundle for serial_sub5.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub5_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] a;
  logic [4:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] y;
  logic       bout;
  logic       busy;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, y, bout, busy, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, y, bout, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, y, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, y, bout, busy
  );
`endif
endinterface

// File: rtl/serial_sub5.sv
// Bit-serial 5-bit subtractor, LSB first through a single borrow flop.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub5 (
  input logic          clk,
  input logic          rst,
  serial_sub5_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] a_sh;
  logic [4:0] b_sh;
  logic [4:0] y_sh;
  logic [4:0] y_q;
  logic       brw;
  logic       bout_q;
  logic [2:0] cnt;
  logic       d;
  logic       brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf_q;
`endif

  // One full-subtractor bit: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic xa, input logic xb, input logic br);
    sub_bit = {(~xa & xb) | (~(xa ^ xb) & br), xa ^ xb ^ br};
  endfunction

  always_comb begin
    {brw_nxt, d} = sub_bit(a_sh[0], b_sh[0], brw);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (cnt == 3'd4)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Result registers only load on the last RUN edge, so they hold through IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      y_sh   <= '0;
      y_q    <= '0;
      brw    <= 1'b0;
      bout_q <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            brw  <= bus.bin;
            cnt  <= '0;
          end
        end
        RUN: begin
          y_sh <= {d, y_sh[4:1]};
          a_sh <= {1'b0, a_sh[4:1]};
          b_sh <= {1'b0, b_sh[4:1]};
          brw  <= brw_nxt;
          cnt  <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            y_q    <= {d, y_sh[4:1]};
            bout_q <= brw_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // On this edge a_sh[0]/b_sh[0] still hold the operand sign bits.
            ovf_q  <= (a_sh[0] != b_sh[0]) & (d != a_sh[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.y         = y_q;
  assign bus.bout      = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub5.sv
// Directed table-driven bench for serial_sub5 with hand-computed results,
// plus sequences for backpressure and mid-operation reset.
module tb_serial_sub5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_sub5_if bus();

  serial_sub5 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic       bin;
    logic [4:0] y;
    logic       bout;
    logic       ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_valid_timeout"}, int'(bus.out_valid), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_idle_timeout"}, int'(bus.busy), 0);
  endtask

  // Issue one op with out_ready high; check latency, busy length and result.
  task automatic run_op(input logic [4:0] a, input logic [4:0] b, input logic bin,
                        input logic [4:0] ey, input logic eb, input logic eo);
    int   lat;
    int   nb;
    logic [4:0] ry;
    logic rb;
    logic ro;
    bus.a         = a;
    bus.b         = b;
    bus.bin       = bin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = -1;
    nb  = 0;
    ry  = '0;
    rb  = 1'b0;
    ro  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.busy) nb++;
      if (bus.out_valid && lat < 0) begin
        lat = i;
        ry  = bus.y;
        rb  = bus.bout;
`ifdef SERIAL_SUB_OVF_EN
        ro  = bus.ovf;
`endif
      end
      if (!bus.busy) break;
      tick();
    end
    chk($sformatf("lat_%0d_%0d_%0d", a, b, bin), lat, 5);
    chk($sformatf("busy_%0d_%0d_%0d", a, b, bin), nb, 6);
    chk($sformatf("y_%0d_%0d_%0d", a, b, bin), int'(ry), int'(ey));
    chk($sformatf("bout_%0d_%0d_%0d", a, b, bin), int'(rb), int'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk($sformatf("ovf_%0d_%0d_%0d", a, b, bin), int'(ro), int'(eo));
`else
    ro = eo;
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            a      b      bin   y      bout  ovf
    vecs[0]  = {5'd9,  5'd3,  1'b0, 5'd6,  1'b0, 1'b0};
    vecs[1]  = {5'd3,  5'd9,  1'b0, 5'd26, 1'b1, 1'b0};
    vecs[2]  = {5'd0,  5'd0,  1'b1, 5'd31, 1'b1, 1'b0};
    vecs[3]  = {5'd31, 5'd31, 1'b0, 5'd0,  1'b0, 1'b0};
    vecs[4]  = {5'd5,  5'd2,  1'b0, 5'd3,  1'b0, 1'b0};
    vecs[5]  = {5'd16, 5'd1,  1'b0, 5'd15, 1'b0, 1'b1};
    vecs[6]  = {5'd15, 5'd31, 1'b0, 5'd16, 1'b1, 1'b1};
    vecs[7]  = {5'd0,  5'd31, 1'b1, 5'd0,  1'b1, 1'b0};
    vecs[8]  = {5'd31, 5'd0,  1'b1, 5'd30, 1'b0, 1'b0};
    vecs[9]  = {5'd10, 5'd10, 1'b1, 5'd31, 1'b1, 1'b0};
    vecs[10] = {5'd16, 5'd0,  1'b1, 5'd15, 1'b0, 1'b1};
    vecs[11] = {5'd20, 5'd7,  1'b0, 5'd13, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a         = 5'd9;
    bus.b         = 5'd3;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_y", int'(bus.y), 0);
    chk("rst_bout", int'(bus.bout), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", int'(bus.ovf), 0);
`endif
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].y, vecs[i].bout, vecs[i].ovf);
    end

    // Backpressure: result must hold while out_ready is low and in_valid is pending.
    bus.out_ready = 1'b0;
    bus.a         = 5'd12;
    bus.b         = 5'd4;
    bus.bin       = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    wait_valid("hold");
    chk("hold_first_y", int'(bus.y), 8);
    bus.a        = 5'd7;
    bus.b        = 5'd0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold_out_valid_%0d", i), int'(bus.out_valid), 1);
      chk($sformatf("hold_in_ready_%0d", i), int'(bus.in_ready), 0);
      chk($sformatf("hold_y_%0d", i), int'(bus.y), 8);
      chk($sformatf("hold_bout_%0d", i), int'(bus.bout), 0);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("handoff_in_ready", int'(bus.in_ready), 1);
    chk("handoff_out_valid", int'(bus.out_valid), 0);
    chk("handoff_y_held", int'(bus.y), 8);
    tick();
    chk("next_accept_busy", int'(bus.busy), 1);
    chk("next_accept_in_ready", int'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    wait_valid("next");
    chk("next_y", int'(bus.y), 7);
    chk("next_bout", int'(bus.bout), 0);
    wait_idle("next");

    // Leave a nonzero result with borrow set, then abort an op mid-RUN.
    run_op(5'd0, 5'd0, 1'b1, 5'd31, 1'b1, 1'b0);
    bus.a        = 5'd9;
    bus.b        = 5'd3;
    bus.bin      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_in_ready", int'(bus.in_ready), 1);
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_y", int'(bus.y), 0);
    chk("abort_bout", int'(bus.bout), 0);
    tick();
    chk("abort_no_accept", int'(bus.busy), 0);
    run_op(5'd5, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_sub5.md
# serial_sub5

Bit-serial 5-bit subtractor with borrow-in and borrow-out. It is the inverse-direction companion to the team's 5-bit ripple adder datapath. The block accepts one operand pair through a valid/ready handshake and resolves one bit per clock, LSB first, through a single borrow flip-flop. It presents the difference through a second valid/ready handshake. It sits between the operand staging logic and the result consumer wherever area matters more than throughput.

## Interface
- No parameters; width is fixed at 5 bits.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  5  minuend
- b  input  5  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- y  output  5  difference, (a - b - bin) mod 32
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
- busy  output  1  high in RUN or DONE
- ovf  output  1  signed overflow (only with SERIAL_SUB_OVF_EN)

## Operation
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid=1, latch a, b into shift registers and bin into the borrow flop.
  - Clear bit counter cnt to 0 and go to RUN.
- RUN:
  - Each edge computes d = a_sh[0] ^ b_sh[0] ^ brw.
  - brw_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw).
  - Shift d into y_sh from the MSB side, shift a_sh and b_sh right, and increment cnt.
  - On the edge with cnt==4, go to DONE.
- DONE:
  - out_valid = 1; y = y_sh; bout = final brw.
  - On an edge with out_ready=1, return to IDLE.
- y and bout update only on the transition into DONE. They hold their value through IDLE until the next DONE.
- in_valid is ignored outside IDLE. Operand inputs need to be stable only on the accept edge.
- out_ready is ignored outside DONE.
- Arithmetic is unsigned modulo 32. There is no saturation.
- Reset overrides everything in any state. State returns to IDLE and cnt, shift registers and brw clear to 0. An in-flight operation is dropped and no result is produced.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0
  - y=0, bout=0, ovf=0
- Latency: the accept edge is T. The RUN edges are T+1 … T+5. out_valid is high in the cycle after edge T+5, i.e. 5 clocks after accept.
- The handoff edge (out_valid & out_ready) returns the FSM to IDLE. The earliest next accept is the following edge.
- Minimum issue interval is 7 clocks.
- in_ready and out_valid are decoded directly from the state register. There are no combinational paths from in_valid or out_ready to any output.
- out_valid stays asserted, with y and bout stable, for as long as out_ready is low.
- If rst and in_valid are both high on the same edge, reset wins and nothing is accepted.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists: ovf = (a[4] != b[4]) & (y[4] != a[4]), treating bin as part of the subtrahend.
  - Computed on the last RUN edge from the latched a[4], b[4] and the final d.
  - Updates and holds together with y, and resets to 0.
- Undefined: port ovf and its register are absent. All other behaviour is identical.

## Test plan
- a=9, b=3, bin=0, accepted at edge T -> out_valid high after edge T+5; y=6, bout=0; busy high for 6 cycles.
- a=3, b=9, bin=0 -> y=26, bout=1.
- a=0, b=0, bin=1 -> y=31, bout=1. Then a=31, b=31, bin=0 -> y=0, bout=0.
- Result ready with out_ready held low 4 cycles while in_valid=1, a=7 -> y, out_valid and in_ready=0 held stable. After out_ready rises, IDLE is entered and a=7 is accepted on the next edge.
- rst pulsed on the third RUN edge -> next cycle state is IDLE: in_ready=1, out_valid=0, y=0, bout=0. A new op a=5, b=2 then yields y=3.
- With SERIAL_SUB_OVF_EN defined:
  - a=16, b=1, bin=0 -> y=15, bout=0, ovf=1.
  - a=15, b=31, bin=0 -> y=16, bout=1, ovf=1.
  - a=5, b=2 -> ovf=0.
